// File: rtl/spi_slave_pkg.sv
// spi_pkg: FSM state encoding and din[9:8] command codes shared by the SPI slave front end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // True when a received command code is legal for the FSM path that collected it.
  function automatic logic cmd_matches_path(spi_state_e st, logic [1:0] cmd);
    logic ok;
    ok = 1'b0;
    case (st)
      WRITE:     ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  ok = (cmd == CMD_RD_ADDR);
      READ_DATA: ok = (cmd == CMD_RD_DATA);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the RAM-side command/read-data handshake.
// cmd_err exists only when SPI_SLAVE_CMD_CHK_EN is defined.
interface spi_slave_if #(parameter int DATA_W = 8);

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

`ifdef SPI_SLAVE_CMD_CHK_EN
  logic              cmd_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, cmd_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, cmd_err
  );
`else
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
`endif

endinterface

// File: rtl/spi_slave_tx_serializer.sv
// spi_tx_serializer: loads a read byte and shifts it out MSB first, pulsing done after the last bit.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      shift_d = data;
      cnt_d   = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q - CNT_W'(1);
      done_d  = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // The line idles low whenever no bits remain to be sent.
  assign miso = (cnt_q != '0) & shift_q[DATA_W-1];
  assign done = done_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: deserializes 10-bit MOSI command frames for the RAM and serializes read bytes onto MISO.
// Optional SPI_SLAVE_CMD_CHK_EN adds cmd_err and drops frames whose command disagrees with the FSM path.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  bus
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 3);

  // Counter values past the last frame bit encode the read-data output phases.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(FRAME_W + 2);

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic [FRAME_W-1:0] frame_word;
  logic               frame_ok;
  logic               tx_load;
  logic               tx_clr;
  logic               tx_done;
  logic               tx_miso;
`ifdef SPI_SLAVE_CMD_CHK_EN
  logic               cmd_err_q, cmd_err_d;
`endif

  assign frame_word = {shift_q, bus.MOSI};

`ifdef SPI_SLAVE_CMD_CHK_EN
  assign frame_ok = cmd_matches_path(state_q, frame_word[FRAME_W-1 -: 2]);
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_load        = 1'b0;
    tx_clr         = 1'b0;
`ifdef SPI_SLAVE_CMD_CHK_EN
    cmd_err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus.SS_n) state_d = CHK_CMD;
      end

      CHK_CMD: begin
        shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
        cnt_d   = CNT_W'(1);
        if (!bus.MOSI)          state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                    state_d = READ_ADD;
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (cnt_q < CNT_WAIT) begin
          shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            if (frame_ok) begin
              rx_data_d  = frame_word;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
            end else begin
`ifdef SPI_SLAVE_CMD_CHK_EN
              cmd_err_d = 1'b1;
`endif
              // A rejected read-data frame never waits for RAM data.
              if (state_q == READ_DATA) cnt_d = CNT_DONE;
            end
          end
        end else if (state_q == READ_DATA) begin
          if ((cnt_q == CNT_WAIT) && bus.tx_valid) begin
            tx_load = 1'b1;
            cnt_d   = CNT_SHIFT;
          end else if ((cnt_q == CNT_SHIFT) && tx_done) begin
            cnt_d = CNT_DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Deselect aborts whatever is in flight without touching the delivered results.
    if ((state_q != IDLE) && bus.SS_n) begin
      state_d        = IDLE;
      cnt_d          = '0;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      tx_load        = 1'b0;
      tx_clr         = 1'b1;
`ifdef SPI_SLAVE_CMD_CHK_EN
      cmd_err_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHK_EN
      cmd_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
`ifdef SPI_SLAVE_CMD_CHK_EN
      cmd_err_q      <= cmd_err_d;
`endif
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tx_clr),
    .load  (tx_load),
    .data  (bus.tx_data),
    .miso  (tx_miso),
    .done  (tx_done)
  );

  assign bus.MISO     = tx_miso;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_CMD_CHK_EN
  assign bus.cmd_err  = cmd_err_q;
`endif

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI-slave/single-port-RAM subsystem. It deserializes MOSI frames into 10-bit command words (`rx_data`/`rx_valid`) for the RAM. For read-data commands, it serializes the RAM's returned byte (`tx_data`/`tx_valid`) onto MISO. It is the initiator side of the `din[9:8]` command protocol the RAM responds to: 00 = write address, 01 = write data, 10 = read address, 11 = read data.

## Interface
- `DATA_W`, default 8: RAM data width; frame width is `DATA_W+2`.

Ports:
- `clk` in 1: system clock; also the SPI bit clock (one bit per rising edge).
- `rst_n` in 1: asynchronous, active-low reset.
- `SS_n` in 1: slave select, active low; frames the transaction.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial data out, MSB first.
- `rx_data` out `DATA_W+2`: assembled command word to the RAM `din`.
- `rx_valid` out 1: one-cycle strobe, `rx_data` valid.
- `tx_data` in `DATA_W`: read byte from the RAM `dout`.
- `tx_valid` in 1: `tx_data` valid.

## Operation
- Reset values:
  - `MISO`=0, `rx_data`=0, `rx_valid`=0.
  - State IDLE, bit counter 0, `rd_addr_seen`=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - `SS_n`=0 → CHK_CMD.
- CHK_CMD:
  - MOSI is shifted in as frame bit 9.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_seen`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_seen`=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA:
  - Shift the remaining 9 bits, MSB first.
  - After the 10th bit, latch the shift register into `rx_data` and pulse `rx_valid`.
- READ_ADD completion sets `rd_addr_seen`. READ_DATA completion clears it.
- WRITE and READ_ADD: after the frame, remain in state with no further action until `SS_n`=1 → IDLE.
- READ_DATA, after `rx_valid`:
  - Wait for `tx_valid`=1 and capture `tx_data`.
  - Drive 8 bits on MISO, MSB first, one per cycle.
  - MISO then returns to 0; wait for `SS_n`=1 → IDLE.
- `SS_n`=1 in any non-IDLE state:
  - IDLE on the next edge; counter cleared.
  - Partial frame discarded: no `rx_valid`; `rx_data` and `rd_addr_seen` unchanged.
  - MISO forced to 0.
- `tx_valid` outside the READ_DATA wait phase is ignored.
- MISO is 0 whenever not in the output phase.

## Timing
- Edge E0: `SS_n` sampled low in IDLE.
- E1: CHK_CMD samples bit 9.
- E2..E10: bits 8..0.
- `rx_valid` is high in the cycle after E10, for exactly one cycle.
- `rx_data` holds until the next completed frame.
- RAM asserts `tx_valid` one cycle after `rx_valid` with command 11. `tx_data` is captured on the first edge with `tx_valid`=1.
- MISO carries `tx_data[7]` in the cycle after capture, then bits 6..0 on successive cycles. Read latency from `rx_valid` to the first MISO bit is 2 cycles at minimum.
- The master must hold `SS_n` low for at least 1+10+2+8 = 21 clocks for a read-data frame, and 11 clocks otherwise.
- Back-to-back frames require at least one cycle with `SS_n`=1 (IDLE) between them.
- Reset mid-frame: immediate return to reset values; no `rx_valid`.

## Configuration
- `SPI_SLAVE_CMD_CHK_EN` defined:
  - Adds output port `cmd_err` (1 bit, reset 0).
  - On frame completion, if `rx_data[9:8]` does not match the FSM path (READ_ADD requires 10, READ_DATA requires 11, WRITE requires 00 or 01):
    - `rx_valid` is suppressed and `cmd_err` pulses one cycle.
    - `rx_data` and `rd_addr_seen` are unchanged.
    - READ_DATA skips the output phase.
- Not defined:
  - No `cmd_err` port.
  - Every completed frame is forwarded as-is.

## Structure
- Package `spi_pkg` holds:
  - state enum typedef `spi_state_e`;
  - command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
- Optional sub-module `spi_tx_serializer`: loads a byte on `tx_valid`, shifts out MSB first, and flags done after 8 bits.

## Test plan
- Reset asserted mid-WRITE frame → MISO=0, `rx_valid`=0, state IDLE, and next frame handled normally.
- Frame 0_0_0x3A (bits 00, address 0x3A) → `rx_data`=10'h03A, one-cycle `rx_valid` after E10; frame 0_1_0x5C → `rx_data`=10'h15C.
- Read-address frame 1_0_0x3A, then read-data frame 1_1_0x00 with `tx_valid`/`tx_data`=0xA5 returned one cycle after `rx_valid` → `rx_data` 10'h23A then 10'h300; MISO serializes 1,0,1,0,0,1,0,1; `rd_addr_seen` ends 0.
- `SS_n` raised after 5 bits of a READ_ADD frame → no `rx_valid`, `rd_addr_seen` stays 0, and the next MOSI=1 frame takes the READ_ADD path.
- `SS_n` held low 30 cycles after read-data output → MISO stays 0 and no second capture on a spurious `tx_valid`.
- With `SPI_SLAVE_CMD_CHK_EN`, READ_ADD path receiving bits 11 → `cmd_err` pulses one cycle, `rx_valid` stays 0, `rd_addr_seen` stays 0.
